// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the shared memory bus to either the icache or the
// dcache through a req/grant/idle handshake. It muxes the owner's request
// channel onto the bus and routes bus responses back to the owner only.
// Ties are broken round-robin. A sticky watchdog flags an owner that holds
// the bus for MAX_HOLD cycles.
//
// Handshake: a cache holds x_busreq high until x_busgrant is seen. While
// granted it owns bus_reqcyc/bus_req/bus_reqtag/bus_respack outright, and it
// alone receives reqack/respcyc/resp/resptag. A one-cycle x_busidle pulse from
// the owner ends the tenure. busidle from a non-owner is ignored.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MAX_HOLD       = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    // tenure handshake
    input  logic                      icache_busreq,
    input  logic                      dcache_busreq,
    input  logic                      icache_busidle,
    input  logic                      dcache_busidle,
    output logic                      icache_busgrant,
    output logic                      dcache_busgrant,
    // per-cache request channels
    input  logic                      icache_bus_reqcyc,
    input  logic                      dcache_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] icache_bus_req,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_bus_reqtag,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_reqtag,
    input  logic                      icache_bus_respack,
    input  logic                      dcache_bus_respack,
    // per-cache routed responses
    output logic                      icache_bus_reqack,
    output logic                      dcache_bus_reqack,
    output logic                      icache_bus_respcyc,
    output logic                      dcache_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] icache_bus_resp,
    output logic [BUS_DATA_WIDTH-1:0] dcache_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  icache_bus_resptag,
    output logic [BUS_TAG_WIDTH-1:0]  dcache_bus_resptag,
    // shared bus
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    // watchdog and debug
    output logic                      hold_timeout,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_I   = 2'd1,
        ST_GNT_D   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d, hold_cnt_inc;
    logic                hold_timeout_q, hold_timeout_d;
    logic                own_i, own_d, own_any;

    assign own_i   = (state_q == ST_GNT_I);
    assign own_d   = (state_q == ST_GNT_D);
    assign own_any = own_i | own_d;

    // Next-state and round-robin pointer: last_d records who was granted last.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            ST_IDLE: begin
                if (icache_busreq && dcache_busreq) begin
                    if (last_d_q) begin
                        state_d  = ST_GNT_I;
                        last_d_d = 1'b0;
                    end else begin
                        state_d  = ST_GNT_D;
                        last_d_d = 1'b1;
                    end
                end else if (icache_busreq) begin
                    state_d  = ST_GNT_I;
                    last_d_d = 1'b0;
                end else if (dcache_busreq) begin
                    state_d  = ST_GNT_D;
                    last_d_d = 1'b1;
                end
            end
            ST_GNT_I: begin
                if (icache_busidle) state_d = ST_RELEASE;
            end
            ST_GNT_D: begin
                if (dcache_busidle) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Watchdog: count held cycles (cleared whenever nobody owns the bus) and
    // latch the flag once MAX_HOLD cycles have been held.
    always_comb begin
        hold_cnt_inc   = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        hold_cnt_d     = own_any ? hold_cnt_inc : '0;
        hold_timeout_d = hold_timeout_q | (own_any && (hold_cnt_inc == HOLD_MAX));
    end

    // All state registers with synchronous reset; icache wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            last_d_q       <= 1'b1;
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign icache_busgrant = own_i;
    assign dcache_busgrant = own_d;
    assign hold_timeout    = hold_timeout_q;
    assign dbg_state       = state_q;

    // Request mux: the owner drives the bus, otherwise the bus is quiet.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        if (own_i) begin
            bus_reqcyc  = icache_bus_reqcyc;
            bus_req     = icache_bus_req;
            bus_reqtag  = icache_bus_reqtag;
            bus_respack = icache_bus_respack;
        end else if (own_d) begin
            bus_reqcyc  = dcache_bus_reqcyc;
            bus_req     = dcache_bus_req;
            bus_reqtag  = dcache_bus_reqtag;
            bus_respack = dcache_bus_respack;
        end
    end

    // Response routing: only the owner sees bus returns; stray responses vanish.
    always_comb begin
        icache_bus_reqack  = 1'b0;
        icache_bus_respcyc = 1'b0;
        icache_bus_resp    = '0;
        icache_bus_resptag = '0;
        dcache_bus_reqack  = 1'b0;
        dcache_bus_respcyc = 1'b0;
        dcache_bus_resp    = '0;
        dcache_bus_resptag = '0;
        if (own_i) begin
            icache_bus_reqack  = bus_reqack;
            icache_bus_respcyc = bus_respcyc;
            icache_bus_resp    = bus_resp;
            icache_bus_resptag = bus_resptag;
        end else if (own_d) begin
            dcache_bus_reqack  = bus_reqack;
            dcache_bus_respcyc = bus_respcyc;
            dcache_bus_resp    = bus_resp;
            dcache_bus_resptag = bus_resptag;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven mux/routing vectors, a randomized
// scoreboard pass, and hand-written handshake/watchdog/reset sequences.
module tb_mem_bus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int MH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GI   = 2'd1;
    localparam logic [1:0] S_GD   = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          icache_busreq, dcache_busreq, icache_busidle, dcache_busidle;
    logic          icache_busgrant, dcache_busgrant;
    logic          icache_bus_reqcyc, dcache_bus_reqcyc;
    logic [DW-1:0] icache_bus_req, dcache_bus_req;
    logic [TW-1:0] icache_bus_reqtag, dcache_bus_reqtag;
    logic          icache_bus_respack, dcache_bus_respack;
    logic          icache_bus_reqack, dcache_bus_reqack;
    logic          icache_bus_respcyc, dcache_bus_respcyc;
    logic [DW-1:0] icache_bus_resp, dcache_bus_resp;
    logic [TW-1:0] icache_bus_resptag, dcache_bus_resptag;
    logic          bus_reqcyc, bus_respack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack, bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          hold_timeout;
    logic [1:0]    dbg_state;

    mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .icache_busreq(icache_busreq), .dcache_busreq(dcache_busreq),
        .icache_busidle(icache_busidle), .dcache_busidle(dcache_busidle),
        .icache_busgrant(icache_busgrant), .dcache_busgrant(dcache_busgrant),
        .icache_bus_reqcyc(icache_bus_reqcyc), .dcache_bus_reqcyc(dcache_bus_reqcyc),
        .icache_bus_req(icache_bus_req), .dcache_bus_req(dcache_bus_req),
        .icache_bus_reqtag(icache_bus_reqtag), .dcache_bus_reqtag(dcache_bus_reqtag),
        .icache_bus_respack(icache_bus_respack), .dcache_bus_respack(dcache_bus_respack),
        .icache_bus_reqack(icache_bus_reqack), .dcache_bus_reqack(dcache_bus_reqack),
        .icache_bus_respcyc(icache_bus_respcyc), .dcache_bus_respcyc(dcache_bus_respcyc),
        .icache_bus_resp(icache_bus_resp), .dcache_bus_resp(dcache_bus_resp),
        .icache_bus_resptag(icache_bus_resptag), .dcache_bus_resptag(dcache_bus_resptag),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .hold_timeout(hold_timeout), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [DW-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string name, input logic [DW-1:0] act);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %0h", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_busreq = 0; dcache_busreq = 0; icache_busidle = 0; dcache_busidle = 0;
        icache_bus_reqcyc = 0; dcache_bus_reqcyc = 0;
        icache_bus_req = '0; dcache_bus_req = '0;
        icache_bus_reqtag = '0; dcache_bus_reqtag = '0;
        icache_bus_respack = 0; dcache_bus_respack = 0;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Reset, then take the DUT into IDLE, GNT_I or GNT_D with a single request.
    task automatic goto_state(input logic [1:0] st);
        do_reset();
        if (st == S_GI) begin
            icache_busreq = 1;
            tick();
            icache_busreq = 0;
        end else if (st == S_GD) begin
            dcache_busreq = 1;
            tick();
            dcache_busreq = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]    st;
        logic          i_reqcyc;  logic [DW-1:0] i_req;  logic [TW-1:0] i_tag;  logic i_respack;
        logic          d_reqcyc;  logic [DW-1:0] d_req;  logic [TW-1:0] d_tag;  logic d_respack;
        logic          b_reqack;  logic b_respcyc; logic [DW-1:0] b_resp; logic [TW-1:0] b_resptag;
        logic          e_reqcyc;  logic [DW-1:0] e_req;  logic [TW-1:0] e_tag;  logic e_respack;
        logic          e_i_reqack; logic e_i_respcyc; logic [DW-1:0] e_i_resp; logic [TW-1:0] e_i_resptag;
        logic          e_d_reqack; logic e_d_respcyc; logic [DW-1:0] e_d_resp; logic [TW-1:0] e_d_resptag;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // GNT_D: dcache drives the bus, dcache alone gets the response.
        vecs[0] = '{S_GD, 1'b1, 64'h5555, 13'h0F0, 1'b0, 1'b1, 64'hDEAD_BEEF, 13'h1A5, 1'b1,
                    1'b1, 1'b1, 64'h1234, 13'h077,
                    1'b1, 64'hDEAD_BEEF, 13'h1A5, 1'b1,
                    1'b0, 1'b0, 64'h0, 13'h0,
                    1'b1, 1'b1, 64'h1234, 13'h077};
        // GNT_I with the same inputs: icache side wins.
        vecs[1] = '{S_GI, 1'b1, 64'h5555, 13'h0F0, 1'b0, 1'b1, 64'hDEAD_BEEF, 13'h1A5, 1'b1,
                    1'b1, 1'b1, 64'h1234, 13'h077,
                    1'b1, 64'h5555, 13'h0F0, 1'b0,
                    1'b1, 1'b1, 64'h1234, 13'h077,
                    1'b0, 1'b0, 64'h0, 13'h0};
        // IDLE: everything quiet, stray response not acked.
        vecs[2] = '{S_IDLE, 1'b1, 64'h5555, 13'h0F0, 1'b1, 1'b1, 64'hDEAD_BEEF, 13'h1A5, 1'b1,
                    1'b1, 1'b1, 64'h1234, 13'h077,
                    1'b0, 64'h0, 13'h0, 1'b0,
                    1'b0, 1'b0, 64'h0, 13'h0,
                    1'b0, 1'b0, 64'h0, 13'h0};
        // GNT_I, all-ones data/tag, respack only.
        vecs[3] = '{S_GI, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 13'h1FFF, 1'b1, 1'b1, 64'hAAAA, 13'h0AA, 1'b1,
                    1'b0, 1'b1, 64'hCAFE_0000_0000_F00D, 13'h1000,
                    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 13'h1FFF, 1'b1,
                    1'b0, 1'b1, 64'hCAFE_0000_0000_F00D, 13'h1000,
                    1'b0, 1'b0, 64'h0, 13'h0};
        // GNT_D, reqack only with MSB/LSB response pattern.
        vecs[4] = '{S_GD, 1'b1, 64'h77, 13'h007, 1'b1, 1'b0, 64'h0, 13'h0, 1'b0,
                    1'b1, 1'b0, 64'h8000_0000_0000_0001, 13'h001,
                    1'b0, 64'h0, 13'h0, 1'b0,
                    1'b0, 1'b0, 64'h0, 13'h0,
                    1'b1, 1'b0, 64'h8000_0000_0000_0001, 13'h001};

        // ---- reset state ----
        clear_inputs();
        reset = 1;
        tick();
        tick();
        check("rst_igrant", icache_busgrant, 0);
        check("rst_dgrant", dcache_busgrant, 0);
        check("rst_reqcyc", bus_reqcyc, 0);
        check("rst_timeout", hold_timeout, 0);
        check("rst_state", dbg_state, S_IDLE);
        reset = 0;

        // ---- table vectors ----
        for (int v = 0; v < 5; v++) begin
            goto_state(vecs[v].st);
            check($sformatf("v%0d_state", v), dbg_state, vecs[v].st);
            icache_bus_reqcyc = vecs[v].i_reqcyc; icache_bus_req = vecs[v].i_req;
            icache_bus_reqtag = vecs[v].i_tag;    icache_bus_respack = vecs[v].i_respack;
            dcache_bus_reqcyc = vecs[v].d_reqcyc; dcache_bus_req = vecs[v].d_req;
            dcache_bus_reqtag = vecs[v].d_tag;    dcache_bus_respack = vecs[v].d_respack;
            bus_reqack = vecs[v].b_reqack; bus_respcyc = vecs[v].b_respcyc;
            bus_resp = vecs[v].b_resp;     bus_resptag = vecs[v].b_resptag;
            #1;
            check($sformatf("v%0d_bus_reqcyc", v), bus_reqcyc, vecs[v].e_reqcyc);
            check($sformatf("v%0d_bus_req", v), bus_req, vecs[v].e_req);
            check($sformatf("v%0d_bus_reqtag", v), bus_reqtag, vecs[v].e_tag);
            check($sformatf("v%0d_bus_respack", v), bus_respack, vecs[v].e_respack);
            check($sformatf("v%0d_i_reqack", v), icache_bus_reqack, vecs[v].e_i_reqack);
            check($sformatf("v%0d_i_respcyc", v), icache_bus_respcyc, vecs[v].e_i_respcyc);
            check($sformatf("v%0d_i_resp", v), icache_bus_resp, vecs[v].e_i_resp);
            check($sformatf("v%0d_i_resptag", v), icache_bus_resptag, vecs[v].e_i_resptag);
            check($sformatf("v%0d_d_reqack", v), dcache_bus_reqack, vecs[v].e_d_reqack);
            check($sformatf("v%0d_d_respcyc", v), dcache_bus_respcyc, vecs[v].e_d_respcyc);
            check($sformatf("v%0d_d_resp", v), dcache_bus_resp, vecs[v].e_d_resp);
            check($sformatf("v%0d_d_resptag", v), dcache_bus_resptag, vecs[v].e_d_resptag);
        end

        // ---- randomized mux/routing through the scoreboard (dcache owner) ----
        goto_state(S_GD);
        for (int k = 0; k < 8; k++) begin
            logic [DW-1:0] r_req, r_resp;
            logic [TW-1:0] r_tag;
            r_req  = {$urandom, $urandom};
            r_resp = {$urandom, $urandom};
            r_tag  = TW'($urandom_range(0, 8191));
            dcache_bus_req = r_req; dcache_bus_reqtag = r_tag; dcache_bus_reqcyc = 1;
            bus_resp = r_resp; bus_respcyc = 1;
            icache_bus_req = ~r_req;
            sb_push(r_req);
            sb_push(DW'(r_tag));
            sb_push(r_resp);
            sb_push('0);
            tick();
            sb_check("rnd_bus_req", bus_req);
            sb_check("rnd_bus_reqtag", DW'(bus_reqtag));
            sb_check("rnd_d_resp", dcache_bus_resp);
            sb_check("rnd_i_resp", icache_bus_resp);
        end

        // ---- single requester: grant latency and release timing ----
        do_reset();
        icache_busreq = 1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("single_igrant_%0d", k), icache_busgrant, 1);
            check($sformatf("single_dgrant_%0d", k), dcache_busgrant, 0);
            if (k == 7) icache_busidle = 1;
            else tick();
        end
        tick();
        icache_busidle = 0;
        icache_busreq  = 0;
        check("single_rel_grant", icache_busgrant, 0);
        check("single_rel_state", dbg_state, S_REL);
        tick();
        check("single_idle_state", dbg_state, S_IDLE);
        tick();
        check("single_no_regrant", icache_busgrant, 0);

        // ---- tie after reset, round-robin, busidle+busreq together ----
        do_reset();
        icache_busreq = 1;
        dcache_busreq = 1;
        tick();
        check("tie1_igrant", icache_busgrant, 1);
        check("tie1_dgrant", dcache_busgrant, 0);
        icache_busidle = 1;
        tick();
        icache_busidle = 0;
        check("tie1_rel_i", icache_busgrant, 0);
        check("tie1_rel_d", dcache_busgrant, 0);
        tick();
        check("tie1_idle_d", dcache_busgrant, 0);
        tick();
        check("tie2_dgrant", dcache_busgrant, 1);
        check("tie2_igrant", icache_busgrant, 0);
        dcache_busidle = 1;
        tick();
        dcache_busidle = 0;
        tick();
        tick();
        check("tie3_igrant", icache_busgrant, 1);
        check("tie3_dgrant", dcache_busgrant, 0);

        // ---- stray busidle, busreq drop while granted, stray response ----
        do_reset();
        icache_busreq = 1;
        tick();
        icache_busreq  = 0;
        dcache_busidle = 1;
        tick();
        dcache_busidle = 0;
        check("stray_idle_igrant", icache_busgrant, 1);
        check("stray_idle_state", dbg_state, S_GI);
        tick();
        check("busreq_drop_igrant", icache_busgrant, 1);
        icache_busidle = 1;
        tick();
        icache_busidle = 0;
        tick();
        check("stray_resp_state", dbg_state, S_IDLE);
        bus_respcyc = 1;
        icache_bus_respack = 1;
        dcache_bus_respack = 1;
        #1;
        check("stray_resp_respack", bus_respack, 0);
        check("stray_resp_i_respcyc", icache_bus_respcyc, 0);
        check("stray_resp_d_respcyc", dcache_bus_respcyc, 0);

        // ---- watchdog: flag from grant cycle MH+1, grant kept, reset clears ----
        do_reset();
        icache_busreq = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("wd_grant_%0d", k), icache_busgrant, 1);
            check($sformatf("wd_flag_%0d", k), hold_timeout, (k >= MH + 1) ? 1'b1 : 1'b0);
        end
        reset = 1;
        tick();
        reset = 0;
        icache_busreq = 0;
        check("wd_reset_flag", hold_timeout, 0);
        check("wd_reset_grant", icache_busgrant, 0);

        // ---- reset mid-tenure of the dcache ----
        goto_state(S_GD);
        dcache_busreq = 1;
        dcache_bus_reqcyc = 1;
        dcache_bus_req = 64'hFEED_FACE;
        bus_respcyc = 1;
        reset = 1;
        tick();
        reset = 0;
        check("midrst_state", dbg_state, S_IDLE);
        check("midrst_dgrant", dcache_busgrant, 0);
        check("midrst_igrant", icache_busgrant, 0);
        check("midrst_reqcyc", bus_reqcyc, 0);
        check("midrst_req", bus_req, 0);
        check("midrst_d_respcyc", dcache_bus_respcyc, 0);
        icache_busreq = 1;
        tick();
        check("midrst_tie_igrant", icache_busgrant, 1);
        check("midrst_tie_dgrant", dcache_busgrant, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
